adau1761_init_sequencer: RTL

Upstream control stage for the ADAU1761 SPI engine. After reset it switches the codec into SPI mode with three dummy writes, waits a settle interval, then walks an external configuration table, issuing one SPI transaction per entry. Entries flagged for polling (the PLL control write) are read back until a lock bit sets. Once initialised, it serves runtime register read/write requests from a host port through the same engine.

---
 rtl/adau1761_init_sequencer.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adau1761_init_sequencer.sv
// adau1761_init_sequencer: wakes the ADAU1761 into SPI mode, replays an
// external configuration table (with PLL lock polling), then serves host
// register accesses. Every access goes through one shared SPI engine handshake.
module adau1761_init_sequencer #(
  parameter int MAX_BYTES     = 8,
  parameter int NUM_CFG       = 16,
  parameter int SETTLE_CYCLES = 1000,
  parameter int POLL_LIMIT    = 64,
  parameter int LOCK_BIT      = 1,
  parameter int BUSY_TIMEOUT  = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  output logic [7:0]                   cfg_index,
  input  logic [15:0]                  cfg_addr,
  input  logic [$clog2(MAX_BYTES)-1:0] cfg_nbytes,
  input  logic [MAX_BYTES*8-1:0]       cfg_data,
  input  logic                         cfg_poll,
  input  logic                         host_req,
  input  logic                         host_read,
  input  logic [$clog2(MAX_BYTES)-1:0] host_nbytes,
  input  logic [15:0]                  host_addr,
  input  logic [MAX_BYTES*8-1:0]       host_wdata,
  output logic                         host_ack,
  output logic [MAX_BYTES*8-1:0]       host_rdata,
  output logic                         spi_start,
  input  logic                         spi_busy,
  output logic                         spi_read,
  output logic [$clog2(MAX_BYTES)-1:0] spi_nbytes,
  output logic [15:0]                  spi_address,
  output logic [MAX_BYTES*8-1:0]       spi_write_data,
  input  logic [MAX_BYTES*8-1:0]       spi_read_data,
  output logic                         init_done,
  output logic                         init_error
);

  localparam int NBW = $clog2(MAX_BYTES);
  localparam int DW  = MAX_BYTES * 8;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam int BCW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [PCW-1:0] POLL_LAST   = PCW'(POLL_LIMIT - 1);
  localparam logic [BCW-1:0] BUSY_MAX    = BCW'(BUSY_TIMEOUT);
  localparam logic [7:0]     LAST_IDX    = 8'(NUM_CFG - 1);
  localparam logic [15:0]    WAKE_ADDR   = 16'h4000;

  // Main sequencer states
  localparam logic [2:0] ST_WAKE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_CFG    = 3'd2;
  localparam logic [2:0] ST_POLL   = 3'd3;
  localparam logic [2:0] ST_READY  = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  // Transaction handshake states
  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_WAIT_BUSY = 2'd1;
  localparam logic [1:0] TX_WAIT_DONE = 2'd2;
  localparam logic [1:0] TX_GAP       = 2'd3;

  logic [2:0]     main_state;
  logic [1:0]     txn_state;
  logic [1:0]     wake_cnt;
  logic [SCW-1:0] settle_cnt;
  logic [PCW-1:0] poll_cnt;
  logic [BCW-1:0] busy_cnt;
  logic           gap_cnt;
  logic           txn_host;
  logic           txn_poll;

  logic           issue_req;
  logic           issue_read;
  logic           issue_host;
  logic           issue_poll;
  logic [NBW-1:0] issue_nbytes;
  logic [15:0]    issue_addr;
  logic [DW-1:0]  issue_wdata;

  logic           txn_done;
  logic           busy_timeout;

  assign txn_done     = (txn_state == TX_WAIT_DONE) && !spi_busy;
  assign busy_timeout = (txn_state == TX_WAIT_BUSY) && !spi_busy && (busy_cnt == BUSY_MAX);

  // Select which caller (wake, table, poll, host) owns the next transaction
  always_comb begin
    issue_req    = 1'b0;
    issue_read   = 1'b0;
    issue_host   = 1'b0;
    issue_poll   = 1'b0;
    issue_nbytes = '0;
    issue_addr   = '0;
    issue_wdata  = '0;
    case (main_state)
      ST_WAKE: begin
        issue_req  = 1'b1;
        issue_addr = WAKE_ADDR;
      end
      ST_CFG: begin
        issue_req    = 1'b1;
        issue_poll   = cfg_poll;
        issue_nbytes = cfg_nbytes;
        issue_addr   = cfg_addr;
        issue_wdata  = cfg_data;
      end
      ST_POLL: begin
        // Readback reuses the address/length latched by the table write.
        issue_req    = 1'b1;
        issue_read   = 1'b1;
        issue_nbytes = spi_nbytes;
        issue_addr   = spi_address;
        issue_wdata  = spi_write_data;
      end
      ST_READY, ST_ERROR: begin
        issue_req    = host_req;
        issue_host   = 1'b1;
        issue_read   = host_read;
        issue_nbytes = host_nbytes;
        issue_addr   = host_addr;
        issue_wdata  = host_wdata;
      end
      default: ;
    endcase
  end

  // SPI engine handshake: issue, wait busy, wait done, enforce start gap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      txn_state      <= TX_IDLE;
      spi_start      <= 1'b0;
      spi_read       <= 1'b0;
      spi_nbytes     <= '0;
      spi_address    <= '0;
      spi_write_data <= '0;
      busy_cnt       <= '0;
      gap_cnt        <= 1'b0;
      txn_host       <= 1'b0;
      txn_poll       <= 1'b0;
      host_ack       <= 1'b0;
      host_rdata     <= '0;
    end else begin
      host_ack <= 1'b0;
      case (txn_state)
        // The issue cycle is folded into the idle edge: fields latch and
        // spi_start rises together.
        TX_IDLE: begin
          if (issue_req) begin
            spi_start      <= 1'b1;
            spi_read       <= issue_read;
            spi_nbytes     <= issue_nbytes;
            spi_address    <= issue_addr;
            spi_write_data <= issue_wdata;
            txn_host       <= issue_host;
            txn_poll       <= issue_poll;
            busy_cnt       <= '0;
            txn_state      <= TX_WAIT_BUSY;
          end
        end
        TX_WAIT_BUSY: begin
          if (spi_busy) begin
            spi_start <= 1'b0;
            txn_state <= TX_WAIT_DONE;
          end else if (busy_cnt == BUSY_MAX) begin
            spi_start <= 1'b0;
            gap_cnt   <= 1'b0;
            txn_state <= TX_GAP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        TX_WAIT_DONE: begin
          if (!spi_busy) begin
            gap_cnt   <= 1'b0;
            txn_state <= TX_GAP;
            if (txn_host) begin
              host_ack <= 1'b1;
              if (spi_read) host_rdata <= spi_read_data;
            end
          end
        end
        default: begin
          if (gap_cnt) txn_state <= TX_IDLE;
          else         gap_cnt   <= 1'b1;
        end
      endcase
    end
  end

  // Init sequence: wake writes, settle delay, table walk with lock polling
  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_state <= ST_WAKE;
      wake_cnt   <= '0;
      settle_cnt <= '0;
      poll_cnt   <= '0;
      cfg_index  <= '0;
      init_done  <= 1'b0;
      init_error <= 1'b0;
    end else if (busy_timeout) begin
      main_state <= ST_ERROR;
      init_error <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      case (main_state)
        ST_WAKE: begin
          if (txn_done) begin
            if (wake_cnt == 2'd2) begin
              main_state <= ST_SETTLE;
              settle_cnt <= '0;
            end else begin
              wake_cnt <= wake_cnt + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            main_state <= ST_CFG;
            cfg_index  <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_CFG: begin
          if (txn_done) begin
            if (txn_poll) begin
              main_state <= ST_POLL;
              poll_cnt   <= '0;
            end else if (cfg_index == LAST_IDX) begin
              main_state <= ST_READY;
              init_done  <= 1'b1;
            end else begin
              cfg_index <= cfg_index + 1'b1;
            end
          end
        end
        ST_POLL: begin
          if (txn_done) begin
            if (spi_read_data[LOCK_BIT]) begin
              if (cfg_index == LAST_IDX) begin
                main_state <= ST_READY;
                init_done  <= 1'b1;
              end else begin
                cfg_index  <= cfg_index + 1'b1;
                main_state <= ST_CFG;
              end
            end else if (poll_cnt == POLL_LAST) begin
              main_state <= ST_ERROR;
              init_error <= 1'b1;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
